adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock; the output registers update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; clears the registered outputs.
REQ-004 a_in  input  32  first operand, unsigned.
REQ-005 b_in  input  32  second operand, unsigned.
REQ-006 car_in  input  1  carry-in, weight 1.
REQ-007 result  output  32  combinational sum bits [31:0].
REQ-008 car_out  output  1  combinational carry-out, weight 2^32.
REQ-009 result_q  output  32  registered copy of result.
REQ-010 car_out_q  output  1  registered copy of car_out.

Function
REQ-011 {car_out, result} SHALL equal the 33-bit unsigned sum a_in + b_in + car_in for every input combination.
REQ-012 result and car_out SHALL be purely combinational, with zero-cycle latency and no dependence on clk or rst_n.
REQ-013 result and car_out SHALL settle within one simulation time step (#1) of any input change.
REQ-014 The sum SHALL be built structurally:
- 8 groups of 4-bit carry-lookahead logic.
- Per-bit generate = a&b, propagate = a^b.
- Group carries per standard CLA equations.
- Carry chained between groups.
- No behavioural "+" operator in the datapath.
REQ-015 Each sum bit SHALL be propagate XOR carry-into-bit.
REQ-016 car_out SHALL be the carry out of bit 31.
REQ-017 Overflow behaviour:
- Wrap-around modulo 2^32 SHALL be reported only through car_out.
- The block SHALL have no signed-overflow output.
REQ-018 Maximum case: a_in=b_in=FFFFFFFF with car_in=1 SHALL give result=FFFFFFFF, car_out=1.
REQ-019 Full carry ripple: a_in=FFFFFFFF, b_in=00000000, car_in=1 SHALL give result=00000000, car_out=1.
REQ-020 On each rising clk edge with rst_n high, result_q and car_out_q SHALL capture the current result and car_out (one-cycle latency).
REQ-021 Inputs SHALL NOT be registered; there SHALL be no handshake, enable or state machine.

Reset
REQ-022 When rst_n goes low, result_q SHALL become 00000000 and car_out_q SHALL become 0 immediately, without waiting for clk.
REQ-023 While rst_n is low, the registered outputs SHALL hold zero; result and car_out SHALL continue to track the inputs.
REQ-024 The first rising clk edge after rst_n deasserts SHALL load the current sum into the registered outputs.
REQ-025 If rst_n is asserted mid-operation, the registered outputs SHALL clear with no residual state.

Verification
REQ-026 All inputs 0:
- Sweep a_in[31:16], a_in[23:8] and a_in[15:0], one window at a time, over 0000..FFFF.
- Repeat for the same windows of b_in.
- Compare result and car_out against the 33-bit reference sum at every step (#1 spacing).
REQ-027 All inputs 1 (a_in=b_in=FFFFFFFF, car_in=1):
- Sweep the same six windows downward from FFFF to 0000.
- Compare against the reference at every step.
REQ-028 Corner vectors:
- 0+0+0 -> 00000000, 0.
- 00000001+FFFFFFFF+0 -> 00000000, 1.
- 7FFFFFFF+00000001+0 -> 80000000, 0.
- FFFFFFFF+FFFFFFFF+1 -> FFFFFFFF, 1.
REQ-029 Register path:
- Apply 12345678+11111111+1.
- After one rising clk edge: result_q=2345678A, car_out_q=0.
- Change the inputs between edges: result_q SHALL be unchanged until the next edge.
REQ-030 Asynchronous reset:
- With result_q nonzero, pull rst_n low between clock edges.
- result_q=0 and car_out_q=0 SHALL appear immediately.
- Release rst_n: the next edge SHALL reload the current sum.

Source files
------------

// File: rtl/adder.sv
// 32-bit unsigned adder built from eight 4-bit carry-lookahead groups, with
// combinational sum outputs and a registered copy of the sum and carry.
module adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        car_in,
  output logic [31:0] result,
  output logic        car_out,
  output logic [31:0] result_q,
  output logic        car_out_q
);

  logic [31:0] gen;
  logic [31:0] prop;
  logic [31:0] carry_into;
  logic        carry_top;
  logic [31:0] result_d;
  logic        car_out_d;

  assign gen  = a_in & b_in;
  assign prop = a_in ^ b_in;

  // Group carries are computed in one procedural chain so the inter-group
  // ripple does not form a combinational loop through a shared vector.
  always_comb begin : cla_chain
    logic [3:0] g;
    logic [3:0] p;
    logic       c0;
    // NOTE: combinational blocks use blocking '=' so each line sees the value
    // computed just above it; every output gets a default to avoid latches.
    carry_into = '0;
    g          = '0;
    p          = '0;
    c0         = car_in;
    for (int grp = 0; grp < 8; grp++) begin
      g = gen[grp*4 +: 4];
      p = prop[grp*4 +: 4];
      carry_into[grp*4]   = c0;
      carry_into[grp*4+1] = g[0] | (p[0] & c0);
      carry_into[grp*4+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      carry_into[grp*4+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                          | (p[2] & p[1] & p[0] & c0);
      c0 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
    end
    carry_top = c0;
  end

  assign result  = prop ^ carry_into;
  assign car_out = carry_top;

  always_comb begin
    result_d  = result;
    car_out_d = car_out;
  end

  // NOTE: sequential state uses non-blocking '<=' and an asynchronous
  // active-low reset, so the outputs clear the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      car_out_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      car_out_q <= car_out_d;
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: corner table, window sweeps, random vectors,
// and hand-written register-path and asynchronous-reset sequences.
module tb_adder;

  logic        clk;
  logic        rst_n;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        car_in;
  logic [31:0] result;
  logic        car_out;
  logic [31:0] result_q;
  logic        car_out_q;

  int total;
  int bad;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] exp_r;
    logic        exp_c;
  } vec_t;

  vec_t vecs[6];

  adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .b_in      (b_in),
    .car_in    (car_in),
    .result    (result),
    .car_out   (car_out),
    .result_q  (result_q),
    .car_out_q (car_out_q)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Reference: plain 33-bit unsigned arithmetic.
  function automatic logic [32:0] ref_sum(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  task automatic check(input string name, input logic [32:0] actual,
                       input logic [32:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic c);
    a_in   = a;
    b_in   = b;
    car_in = c;
  endtask

  // Sweep one 16-bit window of a_in or b_in; every step is compared, and the
  // window is scored as one comparison of its mismatch count against zero.
  task automatic sweep(input bit on_a, input int shift, input bit ones);
    logic [31:0] base;
    logic [31:0] mask;
    logic [31:0] x;
    logic [15:0] val;
    logic [32:0] exp_v;
    int          errs;
    base = ones ? 32'hFFFF_FFFF : 32'h0;
    mask = 32'h0000_FFFF << shift;
    errs = 0;
    for (int i = 0; i < 65536; i++) begin
      val = ones ? 16'(65535 - i) : 16'(i);
      x   = (base & ~mask) | ({16'd0, val} << shift);
      if (on_a) apply(x, base, ones);
      else      apply(base, x, ones);
      #1;
      exp_v = ref_sum(a_in, b_in, car_in);
      if ({car_out, result} !== exp_v) begin
        if (errs == 0)
          $display("sweep step a=%h b=%h c=%b got %h want %h",
                   a_in, b_in, car_in, {car_out, result}, exp_v);
        errs++;
      end
    end
    check($sformatf("sweep %s[%0d+:16] ones=%0d errors", on_a ? "a" : "b",
                    shift, ones), 33'(errs), 33'd0);
  endtask

  initial begin
    logic [32:0] exp_v;
    logic [32:0] held;
    total = 0;
    bad   = 0;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b1};

    // Reset state: registered outputs zero, combinational path live.
    rst_n = 1'b0;
    apply(32'h1234_0000, 32'h0000_5678, 1'b1);
    #1;
    check("reset result_q", {1'b0, result_q}, 33'd0);
    check("reset car_out_q", {32'd0, car_out_q}, 33'd0);
    check("comb during reset", {car_out, result}, 33'h0_1234_5679);
    @(posedge clk); #1;
    check("reset held across edge", {car_out_q, result_q}, 33'd0);

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].c);
      #1;
      check($sformatf("corner %0d", i), {car_out, result},
            {vecs[i].exp_c, vecs[i].exp_r});
    end

    for (int i = 0; i < 3000; i++) begin
      apply($urandom, $urandom, 1'($urandom));
      #1;
      check("random", {car_out, result}, ref_sum(a_in, b_in, car_in));
    end

    for (int w = 0; w < 3; w++) begin
      sweep(1'b1, 16 - 8 * w, 1'b0);
      sweep(1'b0, 16 - 8 * w, 1'b0);
      sweep(1'b1, 16 - 8 * w, 1'b1);
      sweep(1'b0, 16 - 8 * w, 1'b1);
    end

    // Register path: one-cycle latency, hold between edges.
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h1234_5678, 32'h1111_1111, 1'b1);
    @(posedge clk); #1;
    check("reg path load", {car_out_q, result_q}, 33'h0_2345_678A);
    apply(32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    #5;
    check("reg hold between edges", {car_out_q, result_q}, 33'h0_2345_678A);
    check("comb follows new inputs", {car_out, result}, 33'h1_0000_0001);
    @(posedge clk); #1;
    check("reg next edge", {car_out_q, result_q}, 33'h1_0000_0001);

    // Asynchronous reset mid-cycle with nonzero registered outputs.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async clear result_q", {1'b0, result_q}, 33'd0);
    check("async clear car_out_q", {32'd0, car_out_q}, 33'd0);
    apply(32'hDEAD_BEEF, 32'h2152_4111, 1'b1);
    #1;
    exp_v = ref_sum(32'hDEAD_BEEF, 32'h2152_4111, 1'b1);
    check("comb tracks in reset", {car_out, result}, exp_v);
    @(posedge clk); #1;
    check("held zero in reset", {car_out_q, result_q}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h8000_0000, 32'h8000_0001, 1'b0);
    #1;
    check("no residual after release", {car_out_q, result_q}, 33'd0);
    @(posedge clk); #1;
    check("reload after reset", {car_out_q, result_q}, 33'h1_0000_0001);

    // Back-to-back randomized register loads.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      apply($urandom, $urandom, 1'($urandom));
      held = ref_sum(a_in, b_in, car_in);
      @(posedge clk); #1;
      check("random reg load", {car_out_q, result_q}, held);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
